// File: rtl/xres_filter_mc.sv
// xres_filter_mc: multi-channel reset conditioner.
// Per channel: input select, synchroniser, debounce with pulse rejection,
// enable / power-good gating and a stretched release of an active-low reset.
// Optional feature macro: XRES_FILTER_GLITCH_CNT_EN builds glitch_o and the
// saturating per-channel glitch counters; without it they read as zero.
module xres_filter_mc #(
    parameter int NCH         = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 8,
    parameter int STRETCH_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       pad_i,
    input  logic [NCH-1:0]       filt_in_i,
    input  logic [NCH-1:0]       inp_sel_i,
    input  logic [NCH-1:0]       enable_i,
    input  logic                 pwr_good_i,
    input  logic [FILT_W-1:0]    filt_len_i,
    input  logic [STRETCH_W-1:0] stretch_len_i,
    input  logic                 clr_cnt_i,
    output logic [NCH-1:0]       xres_n_o,
    output logic [NCH-1:0]       glitch_o,
    output logic [8*NCH-1:0]     glitch_cnt_o
);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2
    } rel_state_e;

    logic [FILT_W-1:0] len_eff_s;

    // A zero debounce length behaves as one so a level change always needs one sample.
    always_comb begin
        if (filt_len_i == {FILT_W{1'b0}}) begin
            len_eff_s = FILT_W'(1'b1);
        end else begin
            len_eff_s = filt_len_i;
        end
    end

`ifndef XRES_FILTER_GLITCH_CNT_EN
    logic unused_clr_s;
    assign unused_clr_s = clr_cnt_i;
`endif

    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_ch
            logic                 raw_s;
            logic [SYNC_STAGES-1:0] sync_r;
            logic                 s_s;
            logic                 f_r;
            logic [FILT_W-1:0]    dc_r;
            logic [FILT_W:0]      dc_inc_s;
            logic                 accept_s;
            logic                 reject_s;
            logic                 ok_s;
            rel_state_e           state_r;
            rel_state_e           state_nxt_s;
            logic [STRETCH_W-1:0] sc_r;
            logic [STRETCH_W-1:0] sc_nxt_s;

            assign raw_s = inp_sel_i[k] ? filt_in_i[k] : pad_i[k];
            assign s_s   = sync_r[SYNC_STAGES-1];
            assign ok_s  = f_r & enable_i[k] & pwr_good_i;

            // Synchroniser shift chain for the selected raw level.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_r <= {SYNC_STAGES{1'b0}};
                end else begin
                    sync_r <= {sync_r[SYNC_STAGES-2:0], raw_s};
                end
            end

            // Decide whether a mismatch run is long enough to accept, or ended early.
            always_comb begin
                dc_inc_s = {1'b0, dc_r} + {{FILT_W{1'b0}}, 1'b1};
                accept_s = 1'b0;
                reject_s = 1'b0;
                if (s_s != f_r) begin
                    if (dc_inc_s >= {1'b0, len_eff_s}) begin
                        accept_s = 1'b1;
                    end else begin
                        accept_s = 1'b0;
                    end
                end else begin
                    if (dc_r != {FILT_W{1'b0}}) begin
                        reject_s = 1'b1;
                    end else begin
                        reject_s = 1'b0;
                    end
                end
            end

            // Accepted level and mismatch-run counter.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    f_r  <= 1'b0;
                    dc_r <= {FILT_W{1'b0}};
                end else if (accept_s) begin
                    f_r  <= s_s;
                    dc_r <= {FILT_W{1'b0}};
                end else if (s_s != f_r) begin
                    dc_r <= dc_inc_s[FILT_W-1:0];
                end else begin
                    dc_r <= {FILT_W{1'b0}};
                end
            end

            // Release state register and stretch counter.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_r <= ST_ASSERT;
                    sc_r    <= {STRETCH_W{1'b0}};
                end else begin
                    state_r <= state_nxt_s;
                    sc_r    <= sc_nxt_s;
                end
            end

            // Release sequencing: any loss of ok drops straight back to ASSERT.
            always_comb begin
                state_nxt_s = state_r;
                sc_nxt_s    = sc_r;
                case (state_r)
                    ST_ASSERT: begin
                        if (ok_s) begin
                            state_nxt_s = ST_STRETCH;
                            sc_nxt_s    = stretch_len_i;
                        end else begin
                            state_nxt_s = ST_ASSERT;
                        end
                    end
                    ST_STRETCH: begin
                        if (!ok_s) begin
                            state_nxt_s = ST_ASSERT;
                        end else if (sc_r == {STRETCH_W{1'b0}}) begin
                            state_nxt_s = ST_RELEASE;
                        end else begin
                            sc_nxt_s = sc_r - STRETCH_W'(1'b1);
                        end
                    end
                    ST_RELEASE: begin
                        if (!ok_s) begin
                            state_nxt_s = ST_ASSERT;
                        end else begin
                            state_nxt_s = ST_RELEASE;
                        end
                    end
                    default: begin
                        state_nxt_s = ST_ASSERT;
                        sc_nxt_s    = {STRETCH_W{1'b0}};
                    end
                endcase
            end

            // Power-good gates the output directly so its loss needs no clock edge.
            assign xres_n_o[k] = (state_r == ST_RELEASE) & pwr_good_i;

`ifdef XRES_FILTER_GLITCH_CNT_EN
            logic       glitch_r;
            logic [7:0] cnt_r;

            // One-cycle flag for each rejected pulse.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    glitch_r <= 1'b0;
                end else begin
                    glitch_r <= reject_s;
                end
            end

            // Saturating glitch count; a clear beats a simultaneous increment.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_r <= 8'h00;
                end else if (clr_cnt_i) begin
                    cnt_r <= 8'h00;
                end else if (glitch_r && (cnt_r != 8'hFF)) begin
                    cnt_r <= cnt_r + 8'd1;
                end else begin
                    cnt_r <= cnt_r;
                end
            end

            assign glitch_o[k]           = glitch_r;
            assign glitch_cnt_o[8*k +: 8] = cnt_r;
`else
            logic unused_reject_s;
            assign unused_reject_s        = reject_s;
            assign glitch_o[k]            = 1'b0;
            assign glitch_cnt_o[8*k +: 8] = 8'h00;
`endif
        end
    endgenerate

endmodule
